// File: rtl/gpio_tie_pkg.sv
// Shared types and helpers for the staggered GPIO tie-level bank.
package gpio_tie_pkg;

    typedef enum logic [0:0] {ST_RELEASE, ST_RUN} tie_state_e;

    // Widest channel count the group-mask helper can describe.
    localparam int MAX_CH = 256;

    function automatic int ngrp(input int nch, input int grp);
        return (nch + grp - 1) / grp;
    endfunction

    // Bits [g*grp, min((g+1)*grp, nch)-1] set; callers slice to their own width.
    function automatic logic [MAX_CH-1:0] grp_mask(input int nch, input int grp, input int g);
        logic [MAX_CH-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (i >= g * grp && i < (g + 1) * grp && i < nch)
                m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_tie_shadow_chain.sv
// Serial shadow chain with a saturating bit counter that qualifies loads by exact length.
module gpio_tie_shadow_chain
    import gpio_tie_pkg::*;
#(
    parameter int             NCH     = 38,
    parameter logic [NCH-1:0] DEFAULT = 38'h30_0000_00FF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ser_data,
    input  logic           ser_shift,
    input  logic           ser_load,
    output logic [NCH-1:0] shadow,
    output logic           load_ok
);

    localparam int CNT_W = $clog2(NCH + 2);

    logic [CNT_W-1:0] shift_cnt;

    // A load is judged on the count before any same-cycle shift.
    assign load_ok = ser_load && (shift_cnt == CNT_W'(NCH));

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= DEFAULT;
            shift_cnt <= '0;
        end else begin
            if (ser_shift)
                shadow <= {shadow[NCH-2:0], ser_data};
            if (ser_load)
                shift_cnt <= ser_shift ? CNT_W'(1) : '0;
            else if (ser_shift && shift_cnt != CNT_W'(NCH + 1))
                shift_cnt <= shift_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_logic_tie_bank.sv
// Multi-channel tie-level bank: staggered post-reset release plus serial runtime override.
module gpio_logic_tie_bank
    import gpio_tie_pkg::*;
#(
    parameter int             NCH     = 38,
    parameter logic [NCH-1:0] DEFAULT = 38'h30_0000_00FF,
    parameter int             GRP     = 8,
    parameter int             STAGGER = 4
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    input  logic           ser_data_i,
    input  logic           ser_shift_i,
    input  logic           ser_load_i,
    output logic [NCH-1:0] gpio_logic_o,
    output logic           release_done_o,
    output logic           cfg_err_o
);

    localparam int NGRP = ngrp(NCH, GRP);
    localparam int GW   = $clog2(NGRP + 1);
    localparam int SW   = $clog2(STAGGER + 1);

    tie_state_e       state, state_nxt;
    logic [NCH-1:0]   active, mask, mask_nxt, shadow;
    logic [GW-1:0]    grp_idx, grp_idx_nxt;
    logic [SW-1:0]    stag_cnt, stag_nxt;
    logic             done_nxt, load_ok;

    gpio_tie_shadow_chain #(.NCH(NCH), .DEFAULT(DEFAULT)) u_chain (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .ser_data  (ser_data_i),
        .ser_shift (ser_shift_i),
        .ser_load  (ser_load_i),
        .shadow    (shadow),
        .load_ok   (load_ok)
    );

    // Unreleased channels are held low regardless of their configured level.
    assign gpio_logic_o = active & mask;

    always_comb begin
        state_nxt   = state;
        mask_nxt    = mask;
        grp_idx_nxt = grp_idx;
        stag_nxt    = stag_cnt;
        done_nxt    = release_done_o;
        case (state)
            ST_RELEASE: begin
                if (stag_cnt == SW'(STAGGER - 1)) begin
                    mask_nxt    = NCH'(grp_mask(NCH, GRP, int'(grp_idx)) | MAX_CH'(mask));
                    grp_idx_nxt = grp_idx + 1'b1;
                    stag_nxt    = '0;
                    if (grp_idx == GW'(NGRP - 1)) begin
                        state_nxt = ST_RUN;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    stag_nxt = stag_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                mask_nxt = '1;
            end
            default: begin
                state_nxt = ST_RELEASE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state          <= ST_RELEASE;
            active         <= DEFAULT;
            mask           <= '0;
            grp_idx        <= '0;
            stag_cnt       <= '0;
            release_done_o <= 1'b0;
            cfg_err_o      <= 1'b0;
        end else begin
            state          <= state_nxt;
            mask           <= mask_nxt;
            grp_idx        <= grp_idx_nxt;
            stag_cnt       <= stag_nxt;
            release_done_o <= done_nxt;
            if (ser_load_i) begin
                if (load_ok) begin
                    active    <= shadow;
                    cfg_err_o <= 1'b0;
                end else begin
                    cfg_err_o <= 1'b1;
                end
            end
        end
    end

endmodule
